neuron_dot_acc: RTL and testbench

// - Sequential neuron pre-activation stage: streams N_INPUTS (x, w) pairs, forms sum(x*w) + bias, saturates, emits one result.
// - Sits directly upstream of the piecewise-linear sigmoid pipe. data_out feeds the sigmoid data_in.
// - Number format on every data port: BITSIZE-bit sign-magnitude, 1 sign bit, FRAC fractional bits (Q8.15 at default).

---
 rtl/neuron_dot_acc_if.sv | 44 ++++
 rtl/neuron_dot_acc.sv | 222 ++++++++++++++++++++++
 tb/tb_neuron_dot_acc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_dot_acc_if.sv
`default_nettype none
// =====================================================================
// Module   : neuron_dot_acc_if
// Brief    : Beat-input / result-output handshake bundle for the
//            neuron_dot_acc pre-activation stage.
// Config   : NEURON_ACC_SAT_FLAG_EN adds the sat_flag signal.
// Revision : 1.0 - initial release
// =====================================================================
interface neuron_dot_acc_if #(
   parameter int BITSIZE = 24
);
   logic               in_valid;
   logic               in_ready;
   logic [BITSIZE-1:0] x_in;
   logic [BITSIZE-1:0] w_in;
   logic [BITSIZE-1:0] bias;
   logic               out_valid;
   logic               out_ready;
   logic [BITSIZE-1:0] data_out;
`ifdef NEURON_ACC_SAT_FLAG_EN
   logic               sat_flag;

   modport master (
      output in_valid, x_in, w_in, bias, out_ready,
      input  in_ready, out_valid, data_out, sat_flag
   );

   modport slave (
      input  in_valid, x_in, w_in, bias, out_ready,
      output in_ready, out_valid, data_out, sat_flag
   );
`else
   modport master (
      output in_valid, x_in, w_in, bias, out_ready,
      input  in_ready, out_valid, data_out
   );

   modport slave (
      input  in_valid, x_in, w_in, bias, out_ready,
      output in_ready, out_valid, data_out
   );
`endif
endinterface
`default_nettype wire

// File: rtl/neuron_dot_acc.sv
`default_nettype none
// =====================================================================
// Module   : neuron_dot_acc
// Brief    : Sequential neuron pre-activation. Streams N_INPUTS
//            sign-magnitude (x, w) beats, accumulates sum(x*w) + bias
//            in two's complement, saturates and emits one
//            sign-magnitude result (never negative zero).
// Config   : NEURON_ACC_SAT_FLAG_EN - when defined, sat_flag reports
//            that the emitted result was clamped.
// Revision : 1.0 - initial release
// =====================================================================
module neuron_dot_acc #(
   parameter int BITSIZE  = 24,
   parameter int FRAC     = 15,
   parameter int N_INPUTS = 8,
   parameter int ACC_W    = 48
) (
   input wire              clk,
   input wire              reset,
   neuron_dot_acc_if.slave bus
);

   localparam int c_mag_w  = BITSIZE - 1;
   localparam int c_prod_w = 2 * c_mag_w;
   localparam int c_cnt_w  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(N_INPUTS - 1);
   localparam logic [ACC_W-1:0]   c_sat_max   = ACC_W'((64'd1 << c_mag_w) - 64'd1);
   localparam logic [ACC_W-1:0]   c_sat_min   = ACC_W'(0) - c_sat_max;

   typedef enum logic [1:0] {
      S_ACC   = 2'd0,
      S_FLUSH = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_in_ready;
   logic                 w_out_valid;
   logic                 w_load_out;
   logic                 w_hs;
   logic                 w_first;
   logic                 w_last;

   logic [c_cnt_w-1:0]   r_beat;

   // Operand stage: magnitudes and product sign of the accepted beat
   logic                 r_op_vld;
   logic [c_mag_w-1:0]   r_x_mag;
   logic [c_mag_w-1:0]   r_w_mag;
   logic                 r_op_neg;

   // Product stage: truncated, signed product ready to accumulate
   logic [c_prod_w-1:0]  w_mul;
   logic [c_prod_w-1:0]  w_mag_sh;
   logic [ACC_W-1:0]     w_prod_mag;
   logic                 r_prod_vld;
   logic [ACC_W-1:0]     r_prod;

   logic [ACC_W-1:0]     w_bias_mag;
   logic [ACC_W-1:0]     w_bias_tc;
   logic [ACC_W-1:0]     r_acc;

   logic                 w_over;
   logic                 w_under;
   logic [c_mag_w-1:0]   w_abs_lo;
   logic [BITSIZE-1:0]   w_res;
   logic [BITSIZE-1:0]   r_data_out;

   assign w_hs    = bus.in_valid & w_in_ready;
   assign w_first = (r_beat == '0);
   assign w_last  = (r_beat == c_last_beat);

   // Magnitude product, truncated toward zero by dropping FRAC bits
   assign w_mul      = {{c_mag_w{1'b0}}, r_x_mag} * {{c_mag_w{1'b0}}, r_w_mag};
   assign w_mag_sh   = w_mul >> FRAC;
   assign w_prod_mag = ACC_W'(w_mag_sh);

   // Bias converted to two's complement; -0 naturally becomes 0
   assign w_bias_mag = ACC_W'(bus.bias[c_mag_w-1:0]);
   assign w_bias_tc  = bus.bias[BITSIZE-1] ? (ACC_W'(0) - w_bias_mag) : w_bias_mag;

   // Saturation detection and low magnitude bits of the in-range result
   assign w_over   = $signed(r_acc) > $signed(c_sat_max);
   assign w_under  = $signed(r_acc) < $signed(c_sat_min);
   assign w_abs_lo = r_acc[ACC_W-1] ? (c_mag_w'(0) - r_acc[c_mag_w-1:0])
                                    : r_acc[c_mag_w-1:0];

   // Sign-magnitude result; a negative in-range acc is never zero, so no -0
   always_comb begin
      w_res = '0;
      if (w_over) begin
         w_res = {1'b0, {c_mag_w{1'b1}}};
      end else if (w_under) begin
         w_res = {1'b1, {c_mag_w{1'b1}}};
      end else begin
         w_res = {r_acc[ACC_W-1], w_abs_lo};
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_ACC;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_load_out  = 1'b0;
      case (r_state)
         S_ACC: begin
            w_in_ready = 1'b1;
            if (bus.in_valid && w_last) begin
               w_state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // Both pipe stages empty means the last product is in acc
            if (!r_op_vld && !r_prod_vld) begin
               w_load_out  = 1'b1;
               w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_nxt = S_ACC;
            end
         end
         default: w_state_nxt = S_ACC;
      endcase
   end

   // Beat counter within the current neuron
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_beat <= '0;
      end else if (w_hs) begin
         r_beat <= w_last ? '0 : r_beat + 1'b1;
      end
   end

   // Operand capture on each accepted beat
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op_vld <= 1'b0;
         r_x_mag  <= '0;
         r_w_mag  <= '0;
         r_op_neg <= 1'b0;
      end else begin
         r_op_vld <= w_hs;
         if (w_hs) begin
            r_x_mag  <= bus.x_in[c_mag_w-1:0];
            r_w_mag  <= bus.w_in[c_mag_w-1:0];
            r_op_neg <= bus.x_in[BITSIZE-1] ^ bus.w_in[BITSIZE-1];
         end
      end
   end

   // Registered multiply stage with sign applied
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prod_vld <= 1'b0;
         r_prod     <= '0;
      end else begin
         r_prod_vld <= r_op_vld;
         if (r_op_vld) begin
            r_prod <= r_op_neg ? (ACC_W'(0) - w_prod_mag) : w_prod_mag;
         end
      end
   end

   // Accumulator: bias seeds it on beat 0, products add as they arrive
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= '0;
      end else if (w_hs && w_first) begin
         r_acc <= w_bias_tc;
      end else if (r_prod_vld) begin
         r_acc <= r_acc + r_prod;
      end
   end

   // Result register, held stable through the output state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data_out <= '0;
      end else if (w_load_out) begin
         r_data_out <= w_res;
      end
   end

`ifdef NEURON_ACC_SAT_FLAG_EN
   logic r_sat;

   // Clamp indicator, loaded with the result and cleared on output handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sat <= 1'b0;
      end else if (w_load_out) begin
         r_sat <= w_over | w_under;
      end else if (w_out_valid && bus.out_ready) begin
         r_sat <= 1'b0;
      end
   end

   assign bus.sat_flag = r_sat;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.data_out  = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_neuron_dot_acc.sv
`default_nettype none
// =====================================================================
// Module   : tb_neuron_dot_acc
// Brief    : Self-checking bench for neuron_dot_acc with an arithmetic
//            reference model and randomized beats, gaps and stalls.
// Config   : NEURON_ACC_SAT_FLAG_EN also checks sat_flag.
// Revision : 1.0 - initial release
// =====================================================================
`timescale 1ns/1ps
module tb_neuron_dot_acc;

   localparam int     BITSIZE = 24;
   localparam int     FRAC    = 15;
   localparam int     N       = 8;
   localparam int     ACC_W   = 48;
   localparam longint MAXMAG  = (64'sd1 <<< (BITSIZE - 1)) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   neuron_dot_acc_if #(.BITSIZE(BITSIZE)) bus ();

   neuron_dot_acc #(
      .BITSIZE (BITSIZE),
      .FRAC    (FRAC),
      .N_INPUTS(N),
      .ACC_W   (ACC_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [24:0] exp_q[$];
   logic [23:0] tx[N];
   logic [23:0] tw[N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer sum of truncated sign-magnitude products
   function automatic logic [24:0] model(input logic [23:0] b);
      longint      acc;
      longint      pm;
      logic [23:0] r;
      logic        s;
      acc = b[23] ? -longint'(b[22:0]) : longint'(b[22:0]);
      for (int i = 0; i < N; i++) begin
         pm = (longint'(tx[i][22:0]) * longint'(tw[i][22:0])) / (64'sd1 <<< FRAC);
         if (tx[i][23] ^ tw[i][23]) acc = acc - pm;
         else                       acc = acc + pm;
      end
      s = 1'b0;
      if (acc > MAXMAG) begin
         r = 24'h7FFFFF; s = 1'b1;
      end else if (acc < -MAXMAG) begin
         r = 24'hFFFFFF; s = 1'b1;
      end else if (acc < 0) begin
         r = {1'b1, 23'(-acc)};
      end else begin
         r = {1'b0, 23'(acc)};
      end
      return {s, r};
   endfunction

   function automatic logic [23:0] rnd_op(input bit big);
      logic [22:0] m;
      m = big ? 23'($urandom) : 23'($urandom_range(0, 'h3FFFF));
      return {1'($urandom_range(1)), m};
   endfunction

   // Compare process: every cycle a result is presented
   always @(negedge clk) begin
      if (reset && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: data_out=0x%0h presented, no result expected", bus.data_out);
         end else begin
            check("mon_data_out", 32'(bus.data_out), 32'(exp_q[0][23:0]));
`ifdef NEURON_ACC_SAT_FLAG_EN
            check("mon_sat_flag", 32'(bus.sat_flag), 32'(exp_q[0][24]));
`endif
            check("mon_in_ready_low", 32'(bus.in_ready), 32'd0);
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input int i, input logic [23:0] b, input int gap_pct);
      int n;
      while ($urandom_range(99) < gap_pct) begin
         bus.in_valid = 1'b0;
         bus.x_in     = 24'($urandom);
         bus.w_in     = 24'($urandom);
         bus.bias     = 24'($urandom);
         tick();
      end
      bus.in_valid  = 1'b1;
      bus.x_in      = tx[i];
      bus.w_in      = tw[i];
      bus.bias      = (i == 0) ? b : 24'($urandom);
      bus.out_ready = 1'($urandom_range(1));
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: in_ready=0, expected 1 within 20 cycles");
      end
      tick();
   endtask

   task automatic run_neuron(input logic [23:0] b, input int gap_pct, input int hold,
                             input bit chk_lat, input bit chk_lit, input logic [24:0] lit);
      int          lat;
      logic [23:0] d;
      exp_q.push_back(model(b));
      for (int i = 0; i < N; i++) send_beat(i, b, gap_pct);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.out_valid) begin
         checks++;
         errors++;
         $display("FAIL out_valid_timeout: out_valid=0, expected 1 within 40 cycles");
      end
      if (chk_lat) check("latency", 32'(lat), 32'd3);
      if (chk_lit) begin
         check("literal_data_out", 32'(bus.data_out), 32'(lit[23:0]));
`ifdef NEURON_ACC_SAT_FLAG_EN
         check("literal_sat_flag", 32'(bus.sat_flag), 32'(lit[24]));
`endif
      end
      d = bus.data_out;
      repeat (hold) begin
         @(negedge clk);
         check("hold_data_stable", 32'(bus.data_out), 32'(d));
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("out_valid_drop", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] b;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x_in      = '0;
      bus.w_in      = '0;
      bus.bias      = '0;

      // Reset state
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data_out", 32'(bus.data_out), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef NEURON_ACC_SAT_FLAG_EN
      check("rst_sat_flag", 32'(bus.sat_flag), 32'd0);
`endif
      repeat (3) @(negedge clk);
      reset = 1'b1;
      tick();

      // 1.0 * 0.5 eight times = 4.0, with latency check
      for (int i = 0; i < N; i++) begin tx[i] = 24'h008000; tw[i] = 24'h004000; end
      run_neuron(24'h000000, 0, 2, 1'b1, 1'b1, {1'b0, 24'h020000});

      // 1.0 * -1.0 eight times + 1.0 = -7.0
      for (int i = 0; i < N; i++) begin tx[i] = 24'h008000; tw[i] = 24'h808000; end
      run_neuron(24'h008000, 0, 0, 1'b1, 1'b1, {1'b0, 24'h838000});

      // Positive and negative saturation
      for (int i = 0; i < N; i++) begin tx[i] = 24'h7FFFFF; tw[i] = 24'h7FFFFF; end
      run_neuron(24'h000000, 0, 1, 1'b0, 1'b1, {1'b1, 24'h7FFFFF});
      for (int i = 0; i < N; i++) begin tx[i] = 24'h7FFFFF; tw[i] = 24'hFFFFFF; end
      run_neuron(24'h000000, 0, 1, 1'b0, 1'b1, {1'b1, 24'hFFFFFF});

      // -1.0 + 1.0*1.0 + (-0 * w) ... = 0, emitted as +0
      tx[0] = 24'h008000; tw[0] = 24'h008000;
      for (int i = 1; i < N; i++) begin tx[i] = 24'h800000; tw[i] = rnd_op(1'b0); end
      run_neuron(24'h808000, 0, 0, 1'b0, 1'b1, {1'b0, 24'h000000});

      // Same random operands gap-free, then with gaps and a 5-cycle stall
      for (int i = 0; i < N; i++) begin tx[i] = rnd_op(1'b0); tw[i] = rnd_op(1'b0); end
      b = rnd_op(1'b0);
      run_neuron(b, 0, 0, 1'b1, 1'b0, '0);
      run_neuron(b, 45, 5, 1'b0, 1'b0, '0);

      // Reset after four beats discards the partial sum and pending output
      for (int i = 0; i < N; i++) begin tx[i] = 24'h008000; tw[i] = 24'h008000; end
      run_neuron(24'h000000, 0, 0, 1'b0, 1'b1, {1'b0, 24'h040000});
      for (int i = 0; i < N; i++) begin tx[i] = 24'h7FFFFF; tw[i] = 24'h7FFFFF; end
      for (int i = 0; i < 4; i++) send_beat(i, 24'h008000, 0);
      bus.in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_data_out", 32'(bus.data_out), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin tx[i] = 24'h010000; tw[i] = 24'h808000; end
      run_neuron(24'h000000, 0, 0, 1'b1, 1'b1, {1'b0, 24'h880000});

      // Randomized neurons
      for (int t = 0; t < 24; t++) begin
         bit big;
         big = ($urandom_range(3) == 0);
         for (int i = 0; i < N; i++) begin tx[i] = rnd_op(big); tw[i] = rnd_op(big); end
         run_neuron(rnd_op(big), int'($urandom_range(50)), int'($urandom_range(4)),
                    1'b0, 1'b0, '0);
      end

      repeat (4) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
